lfsr_rng: RTL and testbench
===========================

# lfsr_rng

Parametrised random-number generator for game logic. A WIDTH-bit Galois LFSR with seed load and lock-up protection feeds a request/response front end that returns unbiased values in [0, limit) by rejection sampling. Game FSMs ask it for spawn positions, delays and dice rolls. `raw` gives direct access to the LFSR state.

## Interface
- WIDTH, 16: LFSR state width (4..32).
- TAPS, 16'hB400: Galois feedback mask, maximal-length for WIDTH; bit WIDTH-1 must be set.
- SEED, 16'hACE1: reset value, also the substitute for any zero seed; must be non-zero.
- OUT_W, 8: response width, OUT_W ≤ WIDTH.
- MAX_TRY, 8: rejection attempts before fallback (≥1).

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  free-run step of the LFSR while not drawing.
- seed_load  in  1  load seed_data into the LFSR this cycle.
- seed_data  in  WIDTH  seed value.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_limit  in  OUT_W  exclusive upper bound; 0 means unbounded.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  OUT_W  random value.
- raw  out  WIDTH  current LFSR state.

## Operation
- Step function: next = (s >> 1) ^ (s[0] ? TAPS : 0). State is never zero.
- Step priority: seed_load first, then step. A step happens when state is DRAW, or when enable=1 in IDLE/HOLD.
- Seed load: seed_data==0 loads SEED instead.
- FSM states:
  - IDLE: req_ready=1. A req_valid&&req_ready edge latches limit, sets attempt=1, goes to DRAW.
  - DRAW: computes cand = raw[OUT_W-1:0] & mask, where mask = smallest 2^k−1 ≥ limit−1.
    - limit 0 → cand = raw[OUT_W-1:0], accepted.
    - limit 1 → 0, accepted.
    - cand < limit → accept.
    - Else, if attempt == MAX_TRY → accept cand>>1, which is always in range.
    - Else attempt++ and stay in DRAW.
    - Accept registers rsp_data and goes to HOLD.
  - HOLD: rsp_valid=1 and rsp_data stable. rsp_ready → IDLE.
- Seed load during DRAW takes effect; the attempt count is not reset.
- Reset (async, any state): LFSR=SEED, state IDLE, rsp_valid=0, rsp_data=0, attempt=0, req_ready=1 after release.

## Timing
- Request handshake at edge t0; rsp_valid rises after edge t0+a, where a = attempts used (1..MAX_TRY).
- Response handshake at edge t1; req_ready=1 after t1. Minimum request-to-request spacing is 3 edges.
- req_ready is a registered state decode; no combinational path from req_valid or rsp_ready to any output.
- raw updates the edge after a step or load.

## Structure
- Package rng_pkg: state enum (IDLE/DRAW/HOLD) and default TAPS constants for WIDTH 8/16/24/32.
- Sub-module lfsr_core: state register, step, seed load, zero-substitution.
- Top level holds the FSM, mask generation, compare and fallback.

## Test plan
- Reset, then one enable cycle → raw 0xACE1 then 0xE270; rsp_valid=0, req_ready=1.
- 65535 enable steps → no zero state seen; raw returns to 0xACE1 on step 65535.
- seed_load with 0x0000 → raw=0xACE1. Then req limit=1 → rsp_data=0 after 1 attempt.
- seed 0x0007, enable=0, req limit=5 → cand 7 rejected, raw 0xB403, rsp_data=3 after 2 attempts. Repeat with MAX_TRY=1 → rsp_data=3 via fallback (7>>1) after 1 attempt.
- limit=0 → rsp_data = low byte of raw at the DRAW cycle. Hold rsp_ready low 5 cycles → rsp_data stable, req_ready=0.
- Assert reset mid-DRAW → rsp_valid=0 immediately, raw=0xACE1, IDLE after release.

Source files
------------

// File: rtl/rng_pkg.sv
// rng_pkg: shared types and constants for the lfsr_rng block.
//   - rng_state_t : request FSM state encoding (IDLE / DRAW / HOLD)
//   - TAPS_*      : maximal-length Galois feedback masks for common widths
package rng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } rng_state_t;

    // Right-shifting Galois masks; bit WIDTH-1 is always set.
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [23:0] TAPS_24 = 24'hE10000;
    localparam logic [31:0] TAPS_32 = 32'hA3000000;

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: WIDTH-bit Galois LFSR state register.
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset (state <= SEED)
//   step       in   advance the LFSR one position
//   seed_load  in   load seed_data (takes priority over step)
//   seed_data  in   seed value; zero is replaced by SEED
//   lfsr_state out  current LFSR state, never zero
module lfsr_core #(
    parameter int unsigned         WIDTH = 16,
    parameter logic [WIDTH-1:0]    TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0]    SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_data,
    output logic [WIDTH-1:0] lfsr_state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] seed_safe;

    always_comb begin
        stepped   = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        // A zero seed would lock the register up, so fall back to SEED.
        seed_safe = (seed_data == '0) ? SEED : seed_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else if (seed_load) begin
            state_q <= seed_safe;
        end else if (step) begin
            state_q <= stepped;
        end
    end

    assign lfsr_state = state_q;

endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng: random-number generator returning unbiased values in [0, limit)
// by rejection sampling over a Galois LFSR.
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   enable     in   free-run LFSR step while not drawing
//   seed_load  in   load seed_data into the LFSR
//   seed_data  in   seed value (0 selects SEED)
//   req_valid  in   request present
//   req_ready  out  request accepted when high (registered state decode)
//   req_limit  in   exclusive upper bound, 0 = unbounded
//   rsp_valid  out  response present
//   rsp_ready  in   response consumed
//   rsp_data   out  random value, stable while rsp_valid
//   raw        out  current LFSR state
module lfsr_rng
    import rng_pkg::*;
#(
    parameter int unsigned         WIDTH   = 16,
    parameter logic [WIDTH-1:0]    TAPS    = 16'hB400,
    parameter logic [WIDTH-1:0]    SEED    = 16'hACE1,
    parameter int unsigned         OUT_W   = 8,
    parameter int unsigned         MAX_TRY = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_limit,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic [WIDTH-1:0] raw
);

    localparam int unsigned      AW    = $clog2(MAX_TRY + 1);
    localparam logic [AW-1:0]    MAX_A = AW'(MAX_TRY);

    rng_state_t       state_q, state_d;
    logic [OUT_W-1:0] limit_q, limit_d;
    logic [AW-1:0]    attempt_q, attempt_d;
    logic [OUT_W-1:0] data_q, data_d;

    logic             step;
    logic [OUT_W-1:0] limit_m1;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] cand_raw;
    logic [OUT_W-1:0] cand;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .seed_load  (seed_load),
        .seed_data  (seed_data),
        .lfsr_state (raw)
    );

    // Smallest all-ones mask covering limit-1: smear the MSB downwards.
    always_comb begin
        limit_m1 = limit_q - OUT_W'(1);
        mask     = limit_m1;
        for (int unsigned i = 1; i < OUT_W; i++) begin
            mask = mask | (limit_m1 >> i);
        end
        cand_raw = raw[OUT_W-1:0];
        cand     = cand_raw & mask;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            attempt_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            attempt_q <= attempt_d;
            data_q    <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        attempt_d = attempt_q;
        data_d    = data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    limit_d   = req_limit;
                    attempt_d = AW'(1);
                    state_d   = DRAW;
                end
            end
            DRAW: begin
                if (limit_q == '0) begin
                    data_d  = cand_raw;
                    state_d = HOLD;
                end else if (limit_q == OUT_W'(1)) begin
                    data_d  = '0;
                    state_d = HOLD;
                end else if (cand < limit_q) begin
                    data_d  = cand;
                    state_d = HOLD;
                end else if (attempt_q == MAX_A) begin
                    // cand <= mask < 2*limit, so halving lands in range.
                    data_d  = cand >> 1;
                    state_d = HOLD;
                end else begin
                    attempt_d = attempt_q + AW'(1);
                end
            end
            HOLD: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == HOLD);
        step      = (state_q == DRAW) || enable;
    end

    assign rsp_data = data_q;

endmodule

// File: tb/tb_lfsr_rng.sv
module tb_lfsr_rng;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, seed_load, req_valid, rsp_ready;
    logic [15:0] seed_data;
    logic [7:0]  req_limit;
    logic        req_ready, rsp_valid;
    logic [7:0]  rsp_data;
    logic [15:0] raw;

    // second instance with a single attempt, exercising the fallback path
    logic        d1_seed_load, d1_req_valid, d1_rsp_ready;
    logic [15:0] d1_seed_data;
    logic [7:0]  d1_req_limit;
    logic        d1_req_ready, d1_rsp_valid;
    logic [7:0]  d1_rsp_data;
    logic [15:0] d1_raw;

    int n_tests = 0;
    int n_fail  = 0;
    int zero_cnt;

    always #5 clk = ~clk;

    lfsr_rng #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .OUT_W(8), .MAX_TRY(8)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
        .seed_data(seed_data), .req_valid(req_valid), .req_ready(req_ready),
        .req_limit(req_limit), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .raw(raw)
    );

    lfsr_rng #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .OUT_W(8), .MAX_TRY(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(1'b0), .seed_load(d1_seed_load),
        .seed_data(d1_seed_data), .req_valid(d1_req_valid), .req_ready(d1_req_ready),
        .req_limit(d1_req_limit), .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready),
        .rsp_data(d1_rsp_data), .raw(d1_raw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; seed_load = 1'b0; seed_data = '0;
        req_valid = 1'b0; req_limit = '0; rsp_ready = 1'b0;
        d1_seed_load = 1'b0; d1_seed_data = '0; d1_req_valid = 1'b0;
        d1_req_limit = '0; d1_rsp_ready = 1'b0;

        #12;
        check("reset_raw", raw, 32'hACE1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        reset = 1'b1;
        tick();
        check("post_reset_req_ready", req_ready, 1);

        // one enable step
        enable = 1'b1;
        tick();
        check("first_step", raw, 32'hE270);
        check("first_step_rsp_valid", rsp_valid, 0);

        // full period: 65534 more steps must come back to the seed
        zero_cnt = 0;
        for (int i = 2; i <= 65535; i++) begin
            tick();
            if (raw == 16'h0000) zero_cnt++;
        end
        enable = 1'b0;
        check("period_return", raw, 32'hACE1);
        check("no_zero_state", zero_cnt, 0);

        // zero seed substitutes SEED; limit 1 always yields 0
        seed_load = 1'b1; seed_data = 16'h0000;
        tick();
        seed_load = 1'b0;
        check("zero_seed", raw, 32'hACE1);
        req_valid = 1'b1; req_limit = 8'd1;
        tick();
        req_valid = 1'b0;
        check("lim1_req_ready_low", req_ready, 0);
        check("lim1_not_valid_yet", rsp_valid, 0);
        tick();
        check("lim1_rsp_valid", rsp_valid, 1);
        check("lim1_rsp_data", rsp_data, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("lim1_done_valid", rsp_valid, 0);
        check("lim1_done_ready", req_ready, 1);

        // seed 7, limit 5: 7 rejected, next state 0xB403 gives 3
        seed_load = 1'b1; seed_data = 16'h0007;
        tick();
        seed_load = 1'b0;
        req_valid = 1'b1; req_limit = 8'd5;
        tick();
        req_valid = 1'b0;
        tick();
        check("rej_first_not_valid", rsp_valid, 0);
        check("rej_raw_after_reject", raw, 32'hB403);
        tick();
        check("rej_rsp_valid", rsp_valid, 1);
        check("rej_rsp_data", rsp_data, 3);
        check("rej_raw_after_accept", raw, 32'hEE01);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // MAX_TRY=1: fallback 7>>1 after a single attempt
        d1_seed_load = 1'b1; d1_seed_data = 16'h0007;
        tick();
        d1_seed_load = 1'b0;
        d1_req_valid = 1'b1; d1_req_limit = 8'd5;
        tick();
        d1_req_valid = 1'b0;
        tick();
        check("fallback_rsp_valid", d1_rsp_valid, 1);
        check("fallback_rsp_data", d1_rsp_data, 3);
        d1_rsp_ready = 1'b1;
        tick();
        d1_rsp_ready = 1'b0;
        check("fallback_done", d1_req_ready, 1);

        // limit 0: raw low byte, then hold stable under backpressure
        seed_load = 1'b1; seed_data = 16'h1234;
        tick();
        seed_load = 1'b0;
        req_valid = 1'b1; req_limit = 8'd0;
        tick();
        req_valid = 1'b0;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, 8'h34);
            check("hold_req_ready", req_ready, 0);
            tick();
        end
        enable = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("lim0_done", req_ready, 1);

        // limit 200 from seed 0x00C7: cand 0xC7 & 0xFF = 199 < 200 accepted
        seed_load = 1'b1; seed_data = 16'h00C7;
        tick();
        seed_load = 1'b0;
        req_valid = 1'b1; req_limit = 8'd200;
        tick();
        req_valid = 1'b0;
        tick();
        check("lim200_rsp_valid", rsp_valid, 1);
        check("lim200_rsp_data", rsp_data, 8'd199);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // reset in the middle of a draw
        seed_load = 1'b1; seed_data = 16'h0007;
        tick();
        seed_load = 1'b0;
        req_valid = 1'b1; req_limit = 8'd5;
        tick();
        req_valid = 1'b0;
        check("mid_in_draw", req_ready, 0);
        reset = 1'b0;
        #1;
        check("mid_reset_rsp_valid", rsp_valid, 0);
        check("mid_reset_raw", raw, 32'hACE1);
        #2;
        reset = 1'b1;
        tick();
        check("mid_release_ready", req_ready, 1);
        check("mid_release_valid", rsp_valid, 0);
        check("mid_release_raw", raw, 32'hACE1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
